imem_prog_loader: RTL and testbench
===================================

// Module: imem_prog_loader
// PURPOSE
//   UART-driven instruction-memory programming sequencer. Parses a framed byte stream from
//   the UART receiver, assembles 32-bit little-endian words and writes them to instruction
//   memory through a valid/ready write port. Holds the core off via prog_ena (drives
//   memcon_prog_ena, which parks fetch at PC 0) from the first length byte until the load completes.
// PARAMETERS
//   IMEM_WORDS   4096       max words accepted; larger length -> error
//   SYNC_BYTE    8'hA5      frame start byte
//   TIMEOUT_CYC  1000000    max clk cycles between bytes once a frame has started
// PORTS
//   clk          in   1   system clock
//   Rst_n        in   1   synchronous reset, active-low
//   rx_data      in   8   received UART byte
//   rx_valid     in   1   one-cycle strobe, rx_data valid
//   wr_valid     out  1   imem write request
//   wr_ready     in   1   imem write accepted this cycle when high with wr_valid
//   wr_addr      out  32  byte address of write (word_idx*4)
//   wr_data      out  32  write word
//   prog_ena     out  1   core hold / programming active
//   done         out  1   one-cycle pulse on successful load
//   err          out  1   sticky error flag, cleared by next SYNC_BYTE
//   err_code     out  2   0 none, 1 length>IMEM_WORDS, 2 timeout/overrun, 3 checksum
// BEHAVIOUR
//   Reset (Rst_n=0 at posedge): state IDLE; all outputs 0; counters, checksum, timer cleared.
//   Frame: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), 4*N data bytes LSB-first, CSUM.
//   CSUM = 8-bit sum (mod 256) of the 4*N data bytes only.
//   States:
//   - IDLE: rx byte == SYNC_BYTE -> LEN0, clear err/err_code/checksum/word_idx; other bytes ignored.
//   - LEN0: capture LEN_LO -> LEN1. prog_ena=1 from entry into LEN0.
//   - LEN1: capture LEN_HI; N>IMEM_WORDS -> ERR(1); N==0 -> CSUM; else -> DATA, byte_idx=0.
//   - DATA: shift byte into wr_data[8*byte_idx+:8], add to checksum; on 4th byte -> WRITE.
//   - WRITE: wr_valid=1, wr_addr={word_idx,2'b00}; hold addr/data stable until wr_ready.
//     On handshake: word_idx++; word_idx==N -> CSUM, else -> DATA.
//     rx_valid during WRITE (before or on handshake cycle) -> ERR(2) (overrun), write dropped.
//   - CSUM: byte==checksum -> DONE, else ERR(3).
//   - DONE: done=1 for one cycle, prog_ena=0 next cycle -> IDLE.
//   - ERR: err=1 (sticky), err_code set, wr_valid=0 -> IDLE next cycle; prog_ena drops in IDLE.
//   prog_ena=1 in LEN0,LEN1,DATA,WRITE,CSUM,DONE,ERR; 0 in IDLE.
//   Timeout: cycle timer resets on each accepted rx_valid; in any non-IDLE state except
//   DONE/ERR, timer reaching TIMEOUT_CYC -> ERR(2). Timer does not run in IDLE.
//   wr_ready ignored when wr_valid=0. Write latency: WRITE entered cycle after 4th data byte.
//   SYNC_BYTE inside a frame is data, not a restart.
//   Reset mid-frame: abort immediately, no further writes, prog_ena=0, err cleared.
//   Words already written before an error remain in memory; loader does not roll back.
// TESTING
//   A5 02 00 | 13 00 00 00 | 93 00 10 00 | B6 -> writes (0x0,0x00000013),(0x4,0x00100093),
//     done pulse, err=0, prog_ena 1 from LEN_LO accept to done cycle.
//   A5 00 00 00 -> no writes, done pulse; A5 00 00 01 -> err=1, err_code=3.
//   A5 01 10 (N=4097, IMEM_WORDS=4096) -> err_code=1, no wr_valid, back to IDLE.
//   wr_ready held low 50 cycles in WRITE -> wr_addr/wr_data stable; extra rx byte -> err_code=2.
//   TIMEOUT_CYC=100, stop after 2 data bytes -> err_code=2 at cycle 100; new A5 clears err.
//   Rst_n=0 during DATA of word 3 -> outputs 0 next edge; fresh frame then loads correctly.

Source files
------------

// File: rtl/imem_prog_loader_if.sv
// Instruction-memory write port: valid/ready handshake carrying a byte address and a 32-bit word.
interface imem_prog_loader_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);
endinterface

// File: rtl/imem_prog_loader.sv
// UART-framed instruction-memory loader: parses SYNC/LEN/data/CSUM frames and writes
// little-endian words to imem while holding the core off through prog_ena.
//
// state | meaning
// IDLE  | waiting for SYNC_BYTE, core released
// LEN0  | expecting length low byte
// LEN1  | expecting length high byte, range check
// DATA  | assembling a 32-bit word from 4 bytes
// WRITE | presenting word to imem, waiting for wr_ready
// CSUM  | expecting checksum byte
// DONE  | one-cycle done pulse
// ERR   | error latched, return to IDLE
module imem_prog_loader #(
  parameter int          IMEM_WORDS  = 4096,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic                       clk,
  input  logic                       Rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  imem_prog_loader_if.master         wr,
  output logic                       prog_ena,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int             TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  T_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]    N_MAX  = 17'(IMEM_WORDS);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t         state;
  logic [15:0]    len;
  logic [15:0]    word_idx;
  logic [1:0]     byte_idx;
  logic [7:0]     csum;
  logic [TW-1:0]  timer;

  logic           timer_tc;
  logic [15:0]    len_full;
  logic [15:0]    word_nxt;

  assign timer_tc = (timer == '0);
  assign len_full = {rx_data, len[7:0]};
  assign word_nxt = word_idx + 16'd1;

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state       <= IDLE;
      len         <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      csum        <= '0;
      timer       <= '0;
      prog_ena    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
      wr.wr_valid <= 1'b0;
      wr.wr_addr  <= '0;
      wr.wr_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state    <= LEN0;
            err      <= 1'b0;
            err_code <= 2'd0;
            csum     <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            timer    <= T_LOAD;
            prog_ena <= 1'b1;
          end
        end
        DONE, ERR: begin
          state    <= IDLE;
          prog_ena <= 1'b0;
        end
        default: begin
          if (rx_valid) begin
            timer <= T_LOAD;
            case (state)
              LEN0: begin
                len[7:0] <= rx_data;
                state    <= LEN1;
              end
              LEN1: begin
                len <= len_full;
                if ({1'b0, len_full} > N_MAX) begin
                  state    <= ERR;
                  err      <= 1'b1;
                  err_code <= 2'd1;
                end else if (len_full == 16'd0) begin
                  state <= CSUM;
                end else begin
                  state    <= DATA;
                  byte_idx <= '0;
                end
              end
              DATA: begin
                wr.wr_data[{byte_idx, 3'b000} +: 8] <= rx_data;
                csum     <= csum + rx_data;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                  state       <= WRITE;
                  wr.wr_valid <= 1'b1;
                  wr.wr_addr  <= {14'd0, word_idx, 2'b00};
                end
              end
              WRITE: begin
                // A byte arriving before the word is accepted is an overrun; the word is abandoned.
                state       <= ERR;
                err         <= 1'b1;
                err_code    <= 2'd2;
                wr.wr_valid <= 1'b0;
              end
              CSUM: begin
                if (rx_data == csum) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state    <= ERR;
                  err      <= 1'b1;
                  err_code <= 2'd3;
                end
              end
              default: ;
            endcase
          end else if (timer_tc) begin
            state       <= ERR;
            err         <= 1'b1;
            err_code    <= 2'd2;
            wr.wr_valid <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
            if (state == WRITE && wr.wr_ready) begin
              wr.wr_valid <= 1'b0;
              word_idx    <= word_nxt;
              state       <= (word_nxt == len) ? CSUM : DATA;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed frames into the loader; expected writes and done/err events go into scoreboard
// queues that a negedge monitor drains as the DUT produces them.
module tb_imem_prog_loader;

  typedef logic [7:0] byte_q_t[$];

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       prog_ena;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  imem_prog_loader_if wr_if ();

  imem_prog_loader #(.TIMEOUT_CYC(100)) dut (
    .clk      (clk),
    .Rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr       (wr_if),
    .prog_ena (prog_ena),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] wr_q[$];   // {addr, data}
  int          ev_q[$];   // 0 = done pulse, 1..3 = err_code on err rising

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: handshakes and done/err events are compared against the scoreboard queues.
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_if.wr_valid && wr_if.wr_ready) begin
      if (wr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected: got addr 0x%08h data 0x%08h expected none",
                 wr_if.wr_addr, wr_if.wr_data);
      end else begin
        logic [63:0] e;
        e = wr_q.pop_front();
        check("wr_addr", wr_if.wr_addr, e[63:32]);
        check("wr_data", wr_if.wr_data, e[31:0]);
      end
    end
    if (done || (err && !err_prev)) begin
      int got;
      got = done ? 0 : int'(err_code);
      if (ev_q.size() == 0) begin
        total++; bad++;
        $display("FAIL event_unexpected: got %0d expected none", got);
      end else begin
        check("event", 32'(got), 32'(ev_q.pop_front()));
      end
    end
    err_prev = err;
  end

  // Byte is sampled at the next posedge; returns #1 after that edge plus gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_bytes(input byte_q_t q, input int gap);
    foreach (q[i]) send_byte(q[i], gap);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    byte_q_t bq;
    logic    stable;
    int      k;

    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; wr_if.wr_ready = 1'b1;
    tick(3);
    check("rst_wr_valid", 32'(wr_if.wr_valid), 0);
    check("rst_prog_ena", 32'(prog_ena), 0);
    check("rst_done",     32'(done), 0);
    check("rst_err",      32'(err), 0);
    check("rst_err_code", 32'(err_code), 0);
    rst_n = 1'b1;
    tick(2);

    // Two-word frame
    wr_q.push_back({32'h0, 32'h0000_0013});
    wr_q.push_back({32'h4, 32'h0010_0093});
    ev_q.push_back(0);
    send_byte(8'h3C, 2);
    check("idle_ignore_prog_ena", 32'(prog_ena), 0);
    send_byte(8'hA5, 0);
    check("sync_prog_ena", 32'(prog_ena), 1);
    tick(2);
    bq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_bytes(bq, 2);
    check("csum_wait_prog_ena", 32'(prog_ena), 1);
    send_byte(8'hB6, 0);
    check("done_pulse", 32'(done), 1);
    check("done_prog_ena", 32'(prog_ena), 1);
    check("done_err", 32'(err), 0);
    tick(1);
    check("after_done_pulse", 32'(done), 0);
    check("after_done_prog_ena", 32'(prog_ena), 0);
    tick(2);

    // Empty frame
    ev_q.push_back(0);
    bq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_bytes(bq, 2);
    tick(2);

    // Empty frame with wrong checksum
    ev_q.push_back(3);
    bq = '{8'hA5, 8'h00, 8'h00, 8'h01};
    send_bytes(bq, 2);
    check("csum_err", 32'(err), 1);
    check("csum_err_code", 32'(err_code), 3);

    // Oversize length: 0x1001 words
    ev_q.push_back(1);
    bq = '{8'hA5, 8'h01};
    send_bytes(bq, 2);
    check("sync_clears_err", 32'(err), 0);
    send_byte(8'h10, 0);
    check("len_err_code", 32'(err_code), 1);
    check("len_err_wr_valid", 32'(wr_if.wr_valid), 0);
    tick(1);
    check("len_err_prog_ena", 32'(prog_ena), 0);
    tick(3);

    // Stalled write then accept
    wr_q.push_back({32'h0, 32'h4433_2211});
    ev_q.push_back(0);
    bq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    send_bytes(bq, 2);
    wr_if.wr_ready = 1'b0;
    send_byte(8'h44, 0);
    check("stall_wr_valid", 32'(wr_if.wr_valid), 1);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 32'h0 || wr_if.wr_data !== 32'h4433_2211)
        stable = 1'b0;
    end
    check("stall_stable", 32'(stable), 1);
    wr_if.wr_ready = 1'b1;
    tick(2);
    send_byte(8'hAA, 2);
    tick(2);

    // Overrun: extra byte while write is pending
    ev_q.push_back(2);
    bq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03};
    send_bytes(bq, 2);
    wr_if.wr_ready = 1'b0;
    send_byte(8'h04, 1);
    send_byte(8'h55, 0);
    check("overrun_err_code", 32'(err_code), 2);
    check("overrun_wr_valid", 32'(wr_if.wr_valid), 0);
    wr_if.wr_ready = 1'b1;
    tick(3);

    // Timeout after two data bytes
    ev_q.push_back(2);
    bq = '{8'hA5, 8'h02, 8'h00, 8'hDE};
    send_bytes(bq, 2);
    send_byte(8'hAD, 0);
    k = 0;
    while (!err && k < 200) begin
      tick(1);
      k++;
    end
    check("timeout_cycles", 32'(k), 100);
    check("timeout_err_code", 32'(err_code), 2);
    tick(2);
    ev_q.push_back(0);
    send_byte(8'hA5, 0);
    check("sync_clears_timeout_err", 32'(err), 0);
    check("sync_clears_err_code", 32'(err_code), 0);
    tick(2);
    bq = '{8'h00, 8'h00, 8'h00};
    send_bytes(bq, 2);
    tick(2);

    // Reset during the fourth word
    wr_q.push_back({32'h0, 32'h1});
    wr_q.push_back({32'h4, 32'h2});
    wr_q.push_back({32'h8, 32'h3});
    bq = '{8'hA5, 8'h04, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
           8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
    send_bytes(bq, 2);
    rst_n = 1'b0;
    tick(1);
    check("midrst_wr_valid", 32'(wr_if.wr_valid), 0);
    check("midrst_prog_ena", 32'(prog_ena), 0);
    check("midrst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick(2);
    wr_q.push_back({32'h0, 32'hDEAD_BEEF});
    ev_q.push_back(0);
    bq = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
    send_bytes(bq, 2);
    tick(5);

    check("wr_q_drained", 32'(wr_q.size()), 0);
    check("ev_q_drained", 32'(ev_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
